// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: active-low hex patterns
// (bit 0 = segment a ... bit 6 = segment g) and the digit-index width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF   = 7'h7F;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  // Width of the digit index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/multi_digit_led_driver.sv
// N-digit time-multiplexed common-anode 7-segment driver with frame-aligned
// double buffering. Optional leading-zero suppression: define LEADING_ZERO_BLANK_EN.
module multi_digit_led_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Reset asserts asynchronously but releases two clk edges later, in step with clk.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             slot_end;
  logic             frame_end;

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // load is a one-cycle strobe with no back-pressure: every pulse is accepted.
  // It lands in pending, or directly in active when it coincides with frame_end.
  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
  logic                    pend_valid;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      pend_valid  <= 1'b0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
    end else if (frame_end) begin
      pend_valid <= 1'b0;
      if (load) begin
        act_digits <= digits_in;
        act_dp     <= dp_in;
        act_blank  <= blank_in;
      end else if (pend_valid) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
      end
    end else if (load) begin
      pend_digits <= digits_in;
      pend_dp     <= dp_in;
      pend_blank  <= blank_in;
      pend_valid  <= 1'b1;
    end
  end

  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_blank;
  logic       in_dead;
  logic       anode_dark;
  logic       seg_dark;
  logic [6:0] dec_seg;

  assign cur_nib   = act_digits[4*int'(idx) +: 4];
  assign cur_dp    = act_dp[idx];
  assign cur_blank = act_blank[idx];
  assign in_dead   = (int'(cnt) < BLANK_CYCLES);

`ifdef LEADING_ZERO_BLANK_EN
  // A zero is suppressed while everything above it is dark; the anode stays on
  // only if that digit's decimal point must still light.
  logic [NUM_DIGITS-1:0] lz;
  logic                  hi_dark;

  always_comb begin
    lz      = '0;
    hi_dark = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz[i]   = hi_dark && (act_digits[4*i +: 4] == 4'd0);
      hi_dark = hi_dark && ((act_digits[4*i +: 4] == 4'd0) || act_blank[i]);
    end
  end

  assign anode_dark = cur_blank || (lz[idx] && !cur_dp);
  assign seg_dark   = cur_blank || lz[idx];
`else
  assign anode_dark = cur_blank;
  assign seg_dark   = cur_blank;
`endif

  seg7_hex_decoder u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      an         <= (in_dead || anode_dark) ? '1 : ~(NUM_DIGITS'(1) << idx);
      seg        <= (in_dead || seg_dark) ? SEG_OFF : dec_seg;
      dp         <= (in_dead || cur_blank) ? 1'b1 : ~cur_dp;
    end
  end

endmodule
